// File: rtl/fetch_ctrl.sv
// PC sequencer for the instruction-fetch stage: next-PC selection, stall-held redirects, ROM word address.
// Optional fetch-address checking is compiled in when FETCH_CHECK_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int          AW       = 10
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          br_req,
  input  logic [31:0]   br_target,
  input  logic          j_req,
  input  logic [31:0]   j_target,
  input  logic          exc_req,
  input  logic          eret_req,
  input  logic [31:0]   epc,
  output logic [31:0]   PC,
  output logic [31:0]   ADD4,
  output logic [AW-1:0] im_addr,
  output logic          fetch_valid,
  output logic          redir_pend,
  output logic          fetch_fault
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pc_load_s;
  logic [31:0] add4_s;
  logic        fault_s;

  assign add4_s = pc_q + 32'd4;

  // Next-state, next-PC and pending-redirect selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_load_s  = 1'b0;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
        if (exc_req) begin
          pc_d      = EXC_VEC;
          pc_load_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HALT: begin
        pend_d = 1'b0;
        if (exc_req) begin
          state_d   = ST_RUN;
          pc_d      = EXC_VEC;
          pc_load_s = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (exc_req) begin
          pc_d      = EXC_VEC;
          pc_load_s = 1'b1;
          pend_d    = 1'b0;
        end else if (eret_req) begin
          pc_d      = epc;
          pc_load_s = 1'b1;
          pend_d    = 1'b0;
        end else if (stall) begin
          // Hold PC; the newest jump/branch replaces any redirect already parked.
          if (j_req) begin
            pend_d     = 1'b1;
            pend_tgt_d = j_target;
          end else if (br_req) begin
            pend_d     = 1'b1;
            pend_tgt_d = br_target;
          end else begin
            pend_d = pend_q;
          end
        end else if (pend_q) begin
          pc_d      = pend_tgt_q;
          pc_load_s = 1'b1;
          pend_d    = 1'b0;
        end else if (j_req) begin
          pc_d      = j_target;
          pc_load_s = 1'b1;
        end else if (br_req) begin
          pc_d      = br_target;
          pc_load_s = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else begin
          pc_d      = add4_s;
          pc_load_s = 1'b1;
        end
      end
      default: begin
        state_d   = ST_BOOT;
        pc_d      = RESET_PC;
        pc_load_s = 1'b1;
        pend_d    = 1'b0;
      end
    endcase
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef FETCH_CHECK_EN
  localparam logic [31:0] PC_HI = RESET_PC + (32'd4 << AW) - 32'd4;

  logic fault_q, fault_d;

  // EXC_VEC is legal even though it lies outside the ROM window.
  function automatic logic pc_bad(input logic [31:0] pc);
    logic bad;
    if (pc[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (pc == EXC_VEC) begin
      bad = 1'b0;
    end else begin
      bad = (pc < RESET_PC) || (pc > PC_HI);
    end
    return bad;
  endfunction

  // Fault is re-evaluated only when a new PC value is loaded.
  always_comb begin
    fault_d = fault_q;
    if (pc_load_s) begin
      fault_d = pc_bad(pc_d);
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_s = fault_q;
`else
  assign fault_s = 1'b0;
`endif

  assign PC          = pc_q;
  assign ADD4        = add4_s;
  assign im_addr     = pc_q[AW+1:2];
  assign fetch_valid = (state_q == ST_RUN) & ~stall & ~fault_s;
  assign redir_pend  = pend_q;
  assign fetch_fault = fault_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam int          AW       = 10;

  logic          Clk = 1'b0;
  logic          Clr, stall, halt_req, br_req, j_req, exc_req, eret_req;
  logic [31:0]   br_target, j_target, epc;
  logic [31:0]   PC, ADD4;
  logic [AW-1:0] im_addr;
  logic          fetch_valid, redir_pend, fetch_fault;

  fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .AW(AW)) dut (
    .Clk(Clk), .Clr(Clr), .stall(stall), .halt_req(halt_req),
    .br_req(br_req), .br_target(br_target), .j_req(j_req), .j_target(j_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .PC(PC), .ADD4(ADD4), .im_addr(im_addr), .fetch_valid(fetch_valid),
    .redir_pend(redir_pend), .fetch_fault(fetch_fault)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode flags, PC, one parked redirect, fault flag.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_pend_tgt = 32'd0;
  bit          m_boot = 1'b1;
  bit          m_halted = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_fault = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_load(input logic [31:0] v);
    m_pc = v;
`ifdef FETCH_CHECK_EN
    m_fault = (v % 32'd4 != 32'd0) ||
              ((v != EXC_VEC) && ((v < RESET_PC) || (v >= RESET_PC + 32'd4096)));
`endif
  endtask

  task automatic model_step();
    if (Clr) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_halted = 1'b0; m_pend = 1'b0; m_fault = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (exc_req) m_load(EXC_VEC);
    end else if (m_halted) begin
      if (exc_req) begin
        m_halted = 1'b0;
        m_load(EXC_VEC);
      end
    end else if (exc_req) begin
      m_load(EXC_VEC); m_pend = 1'b0;
    end else if (eret_req) begin
      m_load(epc); m_pend = 1'b0;
    end else if (stall) begin
      if (j_req) begin
        m_pend = 1'b1; m_pend_tgt = j_target;
      end else if (br_req) begin
        m_pend = 1'b1; m_pend_tgt = br_target;
      end
    end else if (m_pend) begin
      m_load(m_pend_tgt); m_pend = 1'b0;
    end else if (j_req) begin
      m_load(j_target);
    end else if (br_req) begin
      m_load(br_target);
    end else if (halt_req) begin
      m_halted = 1'b1;
    end else begin
      m_load(m_pc + 32'd4);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_fv;
    exp_fv = {31'd0, (!m_boot && !m_halted && !stall && !m_fault)};
    chk("pc", PC, m_pc);
    chk("add4", ADD4, m_pc + 32'd4);
    chk("im_addr", {22'd0, im_addr}, (m_pc / 32'd4) % 32'd1024);
    chk("fetch_valid", {31'd0, fetch_valid}, exp_fv);
    chk("redir_pend", {31'd0, redir_pend}, {31'd0, m_pend});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle();
    Clr = 1'b0; stall = 1'b0; halt_req = 1'b0; br_req = 1'b0; j_req = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_tgt();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    else if (r == 1) return RESET_PC + 32'd4 * $urandom_range(0, 1023) + 32'd2;
    else return RESET_PC + 32'd4 * $urandom_range(0, 1023);
  endfunction

  initial begin
    idle();
    br_target = 32'd0; j_target = 32'd0; epc = 32'd0;

    // T1: reset, boot bubble, sequential fetch
    Clr = 1'b1;
    tick();
    chk("t1_reset_pc", PC, 32'h3000);
    chk("t1_boot_bubble", {31'd0, fetch_valid}, 32'd0);
    Clr = 1'b0;
    tick();
    chk("t1_pc0", PC, 32'h3000);
    chk("t1_valid", {31'd0, fetch_valid}, 32'd1);
    tick();
    chk("t1_pc1", PC, 32'h3004);
    tick();
    tick();
    chk("t1_pc3", PC, 32'h300C);
    chk("t1_im3", {22'd0, im_addr}, 32'd3);
    tick();
    chk("t2_pc_start", PC, 32'h3010);

    // T2: jump during a 3-cycle stall is parked, then taken
    stall = 1'b1; j_req = 1'b1; j_target = 32'h3100;
    tick();
    j_req = 1'b0;
    tick();
    tick();
    chk("t2_held", PC, 32'h3010);
    chk("t2_pend", {31'd0, redir_pend}, 32'd1);
    stall = 1'b0;
    tick();
    chk("t2_taken", PC, 32'h3100);
    chk("t2_pend_clr", {31'd0, redir_pend}, 32'd0);

    // T3: exception beats stall and pending redirect
    stall = 1'b1; j_req = 1'b1; j_target = 32'h3200;
    tick();
    exc_req = 1'b1; br_req = 1'b1; br_target = 32'h3300;
    tick();
    chk("t3_exc", PC, EXC_VEC);
    chk("t3_pend_clr", {31'd0, redir_pend}, 32'd0);

    // T4: branch then eret
    idle(); br_req = 1'b1; br_target = 32'h3040;
    tick();
    chk("t4_br", PC, 32'h3040);
    idle(); eret_req = 1'b1; epc = 32'h3020;
    tick();
    chk("t4_eret", PC, 32'h3020);

    // T5: halt freezes PC, ignores jumps, leaves on exception
    idle(); j_req = 1'b1; j_target = 32'h3008;
    tick();
    idle(); halt_req = 1'b1;
    tick();
    chk("t5_halt_pc", PC, 32'h3008);
    chk("t5_halt_fv", {31'd0, fetch_valid}, 32'd0);
    idle(); j_req = 1'b1; j_target = 32'h3200;
    tick();
    chk("t5_ign_j", PC, 32'h3008);
    idle(); exc_req = 1'b1;
    tick();
    chk("t5_exc", PC, EXC_VEC);
    chk("t5_run", {31'd0, fetch_valid}, 32'd1);

`ifdef FETCH_CHECK_EN
    // T6: misaligned target faults, aligned in-range target clears it
    idle(); j_req = 1'b1; j_target = 32'h3102;
    tick();
    chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t6_fv", {31'd0, fetch_valid}, 32'd0);
    j_target = 32'h3000;
    tick();
    chk("t6_clear", {31'd0, fetch_fault}, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      Clr       = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 30);
      halt_req  = ($urandom_range(0, 99) < 6);
      j_req     = ($urandom_range(0, 99) < 15);
      br_req    = ($urandom_range(0, 99) < 15);
      exc_req   = ($urandom_range(0, 99) < 5);
      eret_req  = ($urandom_range(0, 99) < 5);
      j_target  = rand_tgt();
      br_target = rand_tgt();
      epc       = rand_tgt();
      tick();
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
